br_resolve: RTL and testbench
=============================

BR_RESOLVE -- requirements
Module: br_resolve

Interface
REQ-001 SHALL have parameter BHT_IDX_W, default 4, meaning log2 of branch-history-table entries (16 entries).
REQ-002 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_valid  input  1  a resolve request is presented this cycle.
REQ-005 SHALL have port i_is_jump  input  1  the request is JAL/JALR (unconditional).
REQ-006 SHALL have port i_funct3  input  3  branch funct3 field.
REQ-007 SHALL have port i_br_less  input  1  less-than flag from the branch comparator.
REQ-008 SHALL have port i_br_equal  input  1  equal flag from the branch comparator.
REQ-009 SHALL have port i_pc  input  32  PC of the resolving instruction.
REQ-010 SHALL have port i_target  input  32  computed branch/jump target.
REQ-011 SHALL have port i_pred_taken  input  1  prediction made at fetch for this instruction.
REQ-012 SHALL have port i_lookup_pc  input  32  fetch-stage PC for prediction lookup.
REQ-013 SHALL have port o_br_un  output  1  unsigned-compare select driven to the comparator.
REQ-014 SHALL have port o_pred_taken  output  1  prediction for i_lookup_pc.
REQ-015 SHALL have port o_redirect  output  1  one-cycle mispredict pulse.
REQ-016 SHALL have port o_redirect_pc  output  32  correct next PC, valid while o_redirect=1.
REQ-017 SHALL have port o_illegal  output  1  one-cycle pulse for reserved funct3.
REQ-018 SHALL have ports o_br_cnt and o_mispred_cnt  output  32 each  resolved-branch and mispredict counters.

Function
REQ-019 o_br_un SHALL be combinational: i_funct3[1] when i_is_jump=0, else 0.
REQ-020 Taken decode SHALL be: 000 eq; 001 !eq; 100 less; 101 !less; 110 less; 111 !less; jump always taken.
REQ-021 funct3 010/011 with i_is_jump=0 SHALL be treated as not-taken, raise o_illegal next cycle, and not update the BHT.
REQ-022 Resolution SHALL be registered: request accepted at edge N drives o_redirect/o_redirect_pc/o_illegal in cycle N+1 only (latency 1).
REQ-023 o_redirect SHALL be 1 iff actual taken != i_pred_taken; o_redirect_pc = taken ? i_target : i_pc+4 (mod 2^32; 0xFFFFFFFC+4 = 0x00000000).
REQ-024 A request presented while o_redirect=1 SHALL be discarded (wrong-path) with no output, BHT or counter effect.
REQ-025 BHT SHALL hold 2-bit saturating counters indexed by pc[BHT_IDX_W+1:2]; conditional branches only update; taken increments (saturate 3), not-taken decrements (saturate 0); jumps do not update.
REQ-026 o_pred_taken SHALL be combinational counter[1] of entry indexed by i_lookup_pc.
REQ-027 Lookup and update to the same index in the same cycle SHALL return the pre-update value (read-before-write).
REQ-028 Back-to-back accepted requests SHALL each resolve independently every cycle.

Reset
REQ-029 When i_rst_n=0 at an edge: o_redirect=0, o_redirect_pc=0, o_illegal=0, all BHT entries=2'b01 (weakly not-taken), counters=0; any in-flight resolution is dropped.
REQ-030 o_pred_taken SHALL read 0 in the cycle after reset.

Configuration
REQ-031 Macro BR_RESOLVE_STATS_EN SHALL compile in the counters: o_br_cnt +1 per accepted non-discarded conditional branch, o_mispred_cnt +1 per o_redirect pulse, both wrapping 0xFFFFFFFF->0.
REQ-032 Without BR_RESOLVE_STATS_EN, o_br_cnt and o_mispred_cnt SHALL be constant 0 and no counter flops synthesized.

Verification
REQ-033 Reset, then lookup pc=0x40 -> o_pred_taken=0; BEQ pc=0x40 eq=1 pred=0 target=0x80 -> next cycle o_redirect=1, o_redirect_pc=0x80.
REQ-034 BLTU funct3=110 -> o_br_un=1 same cycle; BLT funct3=100 -> o_br_un=0.
REQ-035 Three taken BNE at pc=0x10 -> entry saturates at 3; fourth not-taken -> entry 2, o_pred_taken still 1.
REQ-036 BGE not-taken pc=0xFFFFFFFC pred=1 -> o_redirect_pc=0x00000000.
REQ-037 Mispredict then immediate next request -> second request discarded, no o_redirect in following cycle; funct3=010 -> o_illegal pulse, BHT unchanged.
REQ-038 With BR_RESOLVE_STATS_EN: 5 branches, 2 mispredicts -> o_br_cnt=5, o_mispred_cnt=2; reset mid-sequence -> both 0 next cycle.

Source files
------------

// File: rtl/br_resolve.sv
// Branch resolution with a 2-bit saturating BHT predictor and a registered redirect.
// Optional counters are compiled in with BR_RESOLVE_STATS_EN.
module br_resolve #(
    parameter int BHT_IDX_W = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_is_jump,
    input  logic [2:0]  i_funct3,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_target,
    input  logic        i_pred_taken,
    input  logic [31:0] i_lookup_pc,
    output logic        o_br_un,
    output logic        o_pred_taken,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_illegal,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_mispred_cnt
);
    localparam int N = 1 << BHT_IDX_W;

    logic [1:0]           r_bht [N];
    logic                 r_redirect;
    logic                 r_illegal;
    logic [31:0]          r_redirect_pc;

    logic                 w_accept;
    logic                 w_cond;
    logic                 w_bad_f3;
    logic                 w_taken;
    logic                 w_mispred;
    logic                 w_bht_we;
    logic [BHT_IDX_W-1:0] w_upd_idx;
    logic [BHT_IDX_W-1:0] w_lk_idx;
    logic [1:0]           w_ctr;
    logic [1:0]           w_ctr_nxt;
    logic                 w_unused;

    assign w_unused  = ^{i_lookup_pc[31:BHT_IDX_W+2], i_lookup_pc[1:0]};

    // A request arriving during a redirect pulse is on the wrong path.
    assign w_accept  = i_valid & ~r_redirect;
    assign w_cond    = ~i_is_jump;
    assign w_bad_f3  = w_cond & (i_funct3[2:1] == 2'b01);
    assign w_mispred = w_taken != i_pred_taken;
    assign w_bht_we  = w_accept & w_cond & ~w_bad_f3;

    assign w_upd_idx = i_pc[BHT_IDX_W+1:2];
    assign w_lk_idx  = i_lookup_pc[BHT_IDX_W+1:2];
    assign w_ctr     = r_bht[w_upd_idx];

    assign o_br_un       = w_cond & i_funct3[1];
    assign o_pred_taken  = r_bht[w_lk_idx][1];
    assign o_redirect    = r_redirect;
    assign o_redirect_pc = r_redirect_pc;
    assign o_illegal     = r_illegal;

    always_comb begin
        w_taken = 1'b0;
        if (i_is_jump) begin
            w_taken = 1'b1;
        end else begin
            case (i_funct3)
                3'b000:  w_taken = i_br_equal;
                3'b001:  w_taken = ~i_br_equal;
                3'b100:  w_taken = i_br_less;
                3'b101:  w_taken = ~i_br_less;
                3'b110:  w_taken = i_br_less;
                3'b111:  w_taken = ~i_br_less;
                default: w_taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_ctr_nxt = w_ctr;
        if (w_taken) begin
            if (w_ctr != 2'b11) w_ctr_nxt = w_ctr + 2'b01;
        end else begin
            if (w_ctr != 2'b00) w_ctr_nxt = w_ctr - 2'b01;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_redirect    <= 1'b0;
            r_illegal     <= 1'b0;
            r_redirect_pc <= 32'd0;
            for (int i = 0; i < N; i++) r_bht[i] <= 2'b01;
        end else begin
            r_redirect <= w_accept & w_mispred;
            r_illegal  <= w_accept & w_bad_f3;
            if (w_accept)
                r_redirect_pc <= w_taken ? i_target : i_pc + 32'd4;
            if (w_bht_we)
                r_bht[w_upd_idx] <= w_ctr_nxt;
        end
    end

`ifdef BR_RESOLVE_STATS_EN
    logic [31:0] r_br_cnt;
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_br_cnt      <= 32'd0;
            r_mispred_cnt <= 32'd0;
        end else begin
            if (w_bht_we)
                r_br_cnt <= r_br_cnt + 32'd1;
            if (w_accept & w_mispred)
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign o_br_cnt      = r_br_cnt;
    assign o_mispred_cnt = r_mispred_cnt;
`else
    assign o_br_cnt      = 32'd0;
    assign o_mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Scoreboard bench for br_resolve: directed cases then random traffic vs a reference model.
module tb_br_resolve;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        is_jump = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic        br_less = 1'b0;
    logic        br_equal = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] target = 32'd0;
    logic        pred_in = 1'b0;
    logic [31:0] lookup_pc = 32'd0;
    logic        br_un;
    logic        pred_out;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        illegal;
    logic [31:0] br_cnt;
    logic [31:0] mp_cnt;

    br_resolve #(.BHT_IDX_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_is_jump(is_jump),
        .i_funct3(funct3), .i_br_less(br_less), .i_br_equal(br_equal),
        .i_pc(pc), .i_target(target), .i_pred_taken(pred_in),
        .i_lookup_pc(lookup_pc), .o_br_un(br_un), .o_pred_taken(pred_out),
        .o_redirect(redirect), .o_redirect_pc(redirect_pc), .o_illegal(illegal),
        .o_br_cnt(br_cnt), .o_mispred_cnt(mp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          redir;
        logic [31:0] rpc;
        bit          ill;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    int          m_bht[16];
    bit          m_redir = 0;
    logic [31:0] m_bc = 0;
    logic [31:0] m_mc = 0;
    bit          m_init = 0;
`ifdef BR_RESOLVE_STATS_EN
    localparam bit STATS = 1;
`else
    localparam bit STATS = 0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("redirect", {31'd0, redirect}, {31'd0, e.redir});
            if (e.redir) chk("redirect_pc", redirect_pc, e.rpc);
            chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
            chk("br_cnt", br_cnt, e.bc);
            chk("mispred_cnt", mp_cnt, e.mc);
        end
    end

    function automatic bit ref_taken(bit j, int f, bit lt, bit eq);
        if (j) return 1;
        case (f)
            0: return eq;
            1: return !eq;
            4, 6: return lt;
            5, 7: return !lt;
            default: return 0;
        endcase
    endfunction

    task automatic drive(input bit r, input bit v, input bit j, input int f,
                         input bit lt, input bit eq, input logic [31:0] p,
                         input logic [31:0] t, input bit pr, input logic [31:0] lp);
        exp_t e;
        bit   tk, bad, acc;
        int   idx;
        @(negedge clk);
        rst_n = r; valid = v; is_jump = j; funct3 = f[2:0];
        br_less = lt; br_equal = eq; pc = p; target = t;
        pred_in = pr; lookup_pc = lp;
        #1;
        chk("br_un", {31'd0, br_un}, {31'd0, (!j && ((f & 2) != 0))});
        if (r && m_init)
            chk("pred_taken", {31'd0, pred_out}, {31'd0, (m_bht[lp[5:2]] >= 2)});
        e = '{0, 32'd0, 0, 32'd0, 32'd0};
        if (!r) begin
            foreach (m_bht[i]) m_bht[i] = 1;
            m_redir = 0; m_bc = 0; m_mc = 0; m_init = 1;
        end else begin
            acc = v && !m_redir;
            tk  = ref_taken(j, f, lt, eq);
            bad = !j && (f == 2 || f == 3);
            e.redir = acc && (tk != pr);
            e.rpc   = tk ? t : p + 32'd4;
            e.ill   = acc && bad;
            if (acc && !j && !bad) begin
                idx = int'(p[5:2]);
                m_bht[idx] = tk ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                                : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
                if (STATS) m_bc = m_bc + 1;
            end
            if (e.redir && STATS) m_mc = m_mc + 1;
            m_redir = e.redir;
        end
        e.bc = m_bc;
        e.mc = m_mc;
        q.push_back(e);
    endtask

    task automatic idle(input logic [31:0] lp);
        drive(1, 0, 0, 0, 0, 0, 32'd0, 32'd0, 0, lp);
    endtask

    initial begin
        logic [31:0] rp, rl;
        drive(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 0, 32'h40);
        drive(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 0, 32'h40);
        idle(32'h40);
        // BEQ taken, predicted not-taken
        drive(1, 1, 0, 0, 0, 1, 32'h40, 32'h80, 0, 32'h40);
        // wrong-path request right behind the mispredict
        drive(1, 1, 0, 1, 0, 1, 32'h44, 32'h90, 1, 32'h40);
        idle(32'h40);
        // unsigned select
        drive(1, 0, 0, 6, 0, 0, 32'd0, 32'd0, 0, 32'h40);
        drive(1, 0, 0, 4, 0, 0, 32'd0, 32'd0, 0, 32'h40);
        // BNE saturation at pc 0x10 with same-index lookup
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 1, 0, 0, 32'h10, 32'h200, 1, 32'h10);
            idle(32'h10);
        end
        drive(1, 1, 0, 1, 0, 1, 32'h10, 32'h200, 1, 32'h10);
        idle(32'h10);
        idle(32'h10);
        // BGE not-taken at top of address space
        drive(1, 1, 0, 5, 1, 0, 32'hFFFFFFFC, 32'h100, 1, 32'h10);
        idle(32'h10);
        // reserved funct3
        drive(1, 1, 0, 2, 0, 1, 32'h10, 32'h300, 0, 32'h10);
        idle(32'h10);
        // jump predicted not-taken
        drive(1, 1, 1, 0, 0, 0, 32'h20, 32'h400, 0, 32'h20);
        idle(32'h20);
        // reset mid-sequence
        drive(0, 1, 0, 0, 0, 1, 32'h40, 32'h80, 0, 32'h40);
        idle(32'h40);
        for (int k = 0; k < 600; k++) begin
            rp = $urandom_range(0, 9) == 0 ? $urandom : {24'd0, 6'($urandom), 2'b00};
            rl = $urandom_range(0, 3) == 0 ? rp : {24'd0, 6'($urandom), 2'b00};
            drive($urandom_range(0, 79) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0, int'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom), rp, $urandom, 1'($urandom), rl);
        end
        idle(32'd0);
        idle(32'd0);
        @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
